en_up_counter: RTL and testbench
================================

// Module: en_up_counter
// PURPOSE
//   Free-running, enable-gated binary up counter. Each rising clock edge with
//   en=1 increments q by one and wraps from MAX_VAL back to 0. en=0 holds q.
//   Serves as a generic tick/sequence counter in datapath and timing blocks.
//   Provides a synchronous clear, a parallel load and a terminal-count strobe
//   for cascading.
// PARAMETERS
//   WIDTH    4             counter width in bits
//   MAX_VAL  2**WIDTH-1    terminal value; the next increment wraps to 0; must be < 2**WIDTH
// PORTS
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   en      in   1      count enable; q increments when 1, holds when 0
//   clr     in   1      synchronous clear to 0 (tie 0 if unused)
//   load    in   1      synchronous parallel load of d (tie 0 if unused)
//   d       in   WIDTH  load value
//   q       out  WIDTH  current count, registered
//   tc      out  1      terminal count: combinational en & (q==MAX_VAL)
//   wrap    out  1      registered one-cycle pulse in the cycle after q wraps MAX_VAL->0
// BEHAVIOUR
// - Clock and reset
//   - One clock domain (clk).
//   - rst_n=0 asynchronously forces q=0 and wrap=0, independent of clk.
//   - After rst_n deasserts, updates resume on the first rising edge.
// - Next-state priority at each rising edge (highest first)
//   - clr=1            : q<=0
//   - load=1           : q<=d (d > MAX_VAL saturates: q<=MAX_VAL)
//   - en=1, q==MAX_VAL : q<=0, wrap<=1
//   - en=1             : q<=q+1
//   - otherwise        : q holds
//   - wrap<=0 in every case except the wrap case.
// - Timing and width
//   - Latency: q reflects en/clr/load one edge after sampling; no combinational path from inputs to q.
//   - Arithmetic is modulo MAX_VAL+1; no overflow beyond WIDTH bits.
// - Enable and boundary conditions
//   - en deasserting mid-count freezes q at its value.
//   - Re-enabling resumes from the held value, not from 0.
//   - clr and load are honoured even when en=0.
//   - tc is high only when en=1 and q==MAX_VAL. Cascade a next stage by driving its en from tc.
//   - Reset asserted mid-count overrides everything immediately. Nothing is retained across reset.
//   - X/Z on en after reset is not supported; the integrator ties unused inputs.
// TESTING
//   1. rst_n=0 for 2 cycles, en=0 -> q=0, wrap=0, tc=0. Release, en=0 for 1 cycle -> q stays 0.
//   2. en=1 from t=10ns (10ns clk) for 20 edges -> q counts 1..15, then 0 (wrap=1 next cycle), then 1..4. tc=1 only while q=15.
//   3. After 20 counting edges set en=0 for 4 edges -> q holds (4). Re-enable -> q continues 5,6,...
//   4. load=1, d=12, en=1 -> q=12. Next edges give 13,14,15,0. clr=1 with en=1 -> q=0.
//   5. Assert rst_n=0 asynchronously mid-count (q=9, between edges) -> q=0 immediately, before the next edge.
//   6. WIDTH=4, MAX_VAL=9, en=1 -> q sequence 0..9,0 (decade). tc high at 9. load d=14 -> q=9.

Source files
------------

// File: rtl/en_up_counter_if.sv
// Counter control/status bundle: enable, clear, load, load data in; count, strobes out.
// Latency: none, pure wiring.
// Backpressure: none, the counter always accepts its controls.
interface en_up_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;

   // Driver side: the block that controls the counter.
   modport master (
      output en, clr, load, d,
      input  q, tc, wrap
   );

   // Counter side.
   modport slave (
      input  en, clr, load, d,
      output q, tc, wrap
   );
endinterface

// File: rtl/en_up_counter.sv
// Enable-gated modulo (MAX_VAL+1) up counter with sync clear, saturating load, tc and wrap strobes.
// Latency: q and wrap update one clk edge after sampling; tc is combinational from en and q.
// Backpressure: none; every edge is accepted, en=0 simply holds the count.
module en_up_counter #(
   parameter int WIDTH   = 4,
   parameter int MAX_VAL = 2**WIDTH - 1
) (
   input  logic           clk,
   input  logic           rst_n,
   en_up_counter_if.slave cnt
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] d_sat;
   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;
   logic             at_max;

   assign at_max = (cnt.q == MAX_Q);

   // Load values above the terminal value clamp to it. When the terminal value
   // is all-ones no WIDTH-bit load can exceed it, so the compare is dropped.
   generate
      if (MAX_VAL == 2**WIDTH - 1) begin : g_full_range
         assign d_sat = cnt.d;
      end else begin : g_sat_load
         assign d_sat = (cnt.d > MAX_Q) ? MAX_Q : cnt.d;
      end
   endgenerate

   // Terminal-count strobe, used as the enable of a cascaded next stage.
   assign cnt.tc = cnt.en & at_max;

   // Next-state selection: clear beats load beats count; wrap only on the rollover.
   always_comb begin
      q_nxt    = cnt.q;
      wrap_nxt = 1'b0;
      if (cnt.clr) begin
         q_nxt = '0;
      end else if (cnt.load) begin
         q_nxt = d_sat;
      end else if (cnt.en) begin
         if (at_max) begin
            q_nxt    = '0;
            wrap_nxt = 1'b1;
         end else begin
            q_nxt = cnt.q + 1'b1;
         end
      end
   end

   // Count and wrap registers; reset clears both immediately, independent of clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt.q    <= '0;
         cnt.wrap <= 1'b0;
      end else begin
         cnt.q    <= q_nxt;
         cnt.wrap <= wrap_nxt;
      end
   end

endmodule

// File: tb/tb_en_up_counter.sv
// Directed bench for en_up_counter: full-range instance (MAX_VAL=15) and decade instance (MAX_VAL=9).
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_en_up_counter;

   logic clk;
   logic rst_n;
   int   vectors;
   int   errs;

   en_up_counter_if #(.WIDTH(4)) ifa ();
   en_up_counter_if #(.WIDTH(4)) ifb ();

   en_up_counter #(.WIDTH(4)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt   (ifa)
   );

   en_up_counter #(.WIDTH(4), .MAX_VAL(9)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt   (ifb)
   );

   // 10ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   initial begin
      vectors  = 0;
      errs     = 0;
      rst_n    = 1'b0;
      ifa.en   = 1'b0; ifa.clr = 1'b0; ifa.load = 1'b0; ifa.d = 4'd0;
      ifb.en   = 1'b0; ifb.clr = 1'b0; ifb.load = 1'b0; ifb.d = 4'd0;

      // 1. Reset for two edges, then release with en=0.
      tick();
      tick();
      chk("rst_q",    ifa.q,    0);
      chk("rst_wrap", ifa.wrap, 0);
      chk("rst_tc",   ifa.tc,   0);
      rst_n = 1'b1;
      tick();
      chk("idle_q", ifa.q, 0);

      // 2. Twenty counting edges: 1..15, 0 (wrap), 1..4.
      ifa.en = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         chk("cnt_tc", ifa.tc, (i == 16));
         tick();
         chk("cnt_q",    ifa.q,    i % 16);
         chk("cnt_wrap", ifa.wrap, (i == 16));
      end

      // 3. Hold for four edges, then resume from the held value.
      ifa.en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("hold_q", ifa.q, 4);
      end
      ifa.en = 1'b1;
      tick();
      chk("resume_q", ifa.q, 5);
      tick();
      chk("resume_q", ifa.q, 6);

      // 4. Load 12 and count through the wrap, then clear while enabled.
      ifa.load = 1'b1; ifa.d = 4'd12;
      tick();
      chk("load_q", ifa.q, 12);
      ifa.load = 1'b0;
      tick(); chk("post_load_q", ifa.q, 13);
      tick(); chk("post_load_q", ifa.q, 14);
      tick(); chk("post_load_q", ifa.q, 15);
      chk("tc_at_max", ifa.tc, 1);
      tick();
      chk("wrap_q",    ifa.q,    0);
      chk("wrap_set",  ifa.wrap, 1);
      tick();
      chk("wrap_clr",  ifa.wrap, 0);
      tick();
      chk("pre_clr_q", ifa.q, 2);
      ifa.clr = 1'b1;
      tick();
      chk("clr_en_q", ifa.q, 0);
      // Clear beats load.
      ifa.load = 1'b1; ifa.d = 4'd5;
      tick();
      chk("clr_over_load", ifa.q, 0);
      // Load honoured with en=0, then clear honoured with en=0.
      ifa.clr = 1'b0; ifa.en = 1'b0; ifa.d = 4'd7;
      tick();
      chk("load_no_en", ifa.q, 7);
      ifa.load = 1'b0; ifa.clr = 1'b1;
      tick();
      chk("clr_no_en", ifa.q, 0);
      ifa.clr = 1'b0;

      // 5. Asynchronous reset at q=9, between edges.
      ifa.en = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      chk("pre_rst_q", ifa.q, 9);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_q", ifa.q, 0);
      tick();
      chk("rst_hold_q", ifa.q, 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_q", ifa.q, 1);
      // Reset also kills a pending wrap pulse.
      for (int i = 0; i < 14; i++) tick();
      chk("pre_wrap_q", ifa.q, 15);
      tick();
      chk("wrap_before_rst", ifa.wrap, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_wrap", ifa.wrap, 0);
      tick();
      rst_n  = 1'b1;
      ifa.en = 1'b0;

      // 6. Decade counter: 0..9, 0 with tc at 9; load 14 saturates to 9.
      ifb.en = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         chk("dec_tc", ifb.tc, (i == 10));
         tick();
         chk("dec_q",    ifb.q,    i % 10);
         chk("dec_wrap", ifb.wrap, (i == 10));
      end
      ifb.en = 1'b0;
      tick();
      chk("dec_hold_q", ifb.q, 0);
      ifb.load = 1'b1; ifb.d = 4'd14;
      tick();
      chk("dec_sat_load", ifb.q, 9);
      ifb.load = 1'b0;
      chk("dec_tc_no_en", ifb.tc, 0);
      ifb.en = 1'b1;
      #1;
      chk("dec_tc_en", ifb.tc, 1);
      tick();
      chk("dec_wrap_q",    ifb.q,    0);
      chk("dec_wrap_puls", ifb.wrap, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
